// File: rtl/keccak_pkg.sv
// Shared Keccak types for the squeeze path: lane and state arrays, SHAKE rates,
// and the serializer FSM encoding.
package keccak_pkg;

    typedef logic [63:0] lane_t;

    // Indexed as A[x][y].
    typedef lane_t [0:4][0:4] state_t;

    localparam int unsigned RATE_BYTES_SHAKE256 = 136;
    localparam int unsigned RATE_BYTES_SHAKE128 = 168;

    typedef enum logic [1:0] {
        StIdle,
        StWaitSt,
        StEmit,
        StDone
    } sq_state_e;

endpackage

// File: rtl/squeeze_serializer_if.sv
// Control, state-input and byte-stream signals of the squeeze serializer.
// The master side drives requests and the permuted state; the slave side is the serializer.
interface squeeze_serializer_if;
    import keccak_pkg::*;

    logic        start;
    logic [15:0] out_len;
    state_t      a_in;
    logic        a_valid;
    logic        a_ready;
    logic        perm_req;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    modport master (
        output start, out_len, a_in, a_valid, out_ready,
        input  a_ready, perm_req, out_byte, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, out_len, a_in, a_valid, out_ready,
        output a_ready, perm_req, out_byte, out_valid, out_last, busy, done
    );

endinterface

// File: rtl/squeeze_serializer_lane_byte_mux.sv
// Selects byte idx of the captured rate lanes, little-endian within each lane, lane 0 first.
// The output is forced to zero when not enabled.
module lane_byte_mux
    import keccak_pkg::*;
#(
    parameter int unsigned RateLanes = 17
) (
    input  lane_t [RateLanes-1:0] lanes_i,
    input  logic  [7:0]           idx_i,
    input  logic                  en_i,
    output logic  [7:0]           byte_o
);

    always_comb begin
        byte_o = '0;
        if (en_i) begin
            for (int i = 0; i < RateLanes; i++) begin
                if (idx_i[7:3] == 5'(i)) begin
                    byte_o = lanes_i[i][{idx_i[2:0], 3'b000} +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/squeeze_serializer.sv
// Turns permuted Keccak states into a byte stream of a requested length, asking for a
// fresh permutation each time the rate portion of the state runs out.
module squeeze_serializer
    import keccak_pkg::*;
#(
    parameter int unsigned RATE_BYTES = RATE_BYTES_SHAKE256
) (
    input logic                  clk,
    input logic                  rst,
    squeeze_serializer_if.slave  sq
);

    localparam int unsigned RateLanes = RATE_BYTES / 8;
    localparam logic [7:0]  LastIdx   = 8'(RATE_BYTES - 1);

    sq_state_e               state_q, state_d;
    logic [15:0]             remaining_q, remaining_d;
    logic [7:0]              idx_q, idx_d;
    logic                    perm_req_q, perm_req_d;
    lane_t [RateLanes-1:0]   lanes_q, lanes_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        perm_req_d  = 1'b0;
        lanes_d     = lanes_q;
        unique case (state_q)
            StIdle: begin
                if (sq.start) begin
                    if (sq.out_len != 16'd0) begin
                        remaining_d = sq.out_len;
                        state_d     = StWaitSt;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWaitSt: begin
                if (sq.a_valid) begin
                    // Only rate lanes are kept; lane i lives at A[i mod 5][i / 5].
                    for (int i = 0; i < RateLanes; i++) begin
                        lanes_d[i] = sq.a_in[i % 5][i / 5];
                    end
                    idx_d   = 8'd0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (sq.out_ready) begin
                    remaining_d = remaining_q - 16'd1;
                    idx_d       = idx_q + 8'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = StDone;
                    end else if (idx_q == LastIdx) begin
                        state_d    = StWaitSt;
                        perm_req_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= 16'd0;
            idx_q       <= 8'd0;
            perm_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            perm_req_q  <= perm_req_d;
        end
    end

    // The lane buffer is pure data and is only ever read in StEmit, so it needs no reset.
    always_ff @(posedge clk) begin
        lanes_q <= lanes_d;
    end

    lane_byte_mux #(
        .RateLanes (RateLanes)
    ) u_lane_byte_mux (
        .lanes_i (lanes_q),
        .idx_i   (idx_q),
        .en_i    (state_q == StEmit),
        .byte_o  (sq.out_byte)
    );

    assign sq.a_ready   = (state_q == StWaitSt);
    assign sq.perm_req  = perm_req_q;
    assign sq.out_valid = (state_q == StEmit);
    assign sq.out_last  = (state_q == StEmit) && (remaining_q == 16'd1);
    assign sq.busy      = (state_q != StIdle);
    assign sq.done      = (state_q == StDone);

endmodule
